// File: rtl/conv_pkg.sv
// conv_pkg: shared helpers and default widths for the N-channel convolution MAC.
//   clog2       ceil(log2(n)), 0 for n <= 1
//   level_cnt   number of live terms at adder-tree level lvl (level 0 = inputs)
//   acc_width   accumulator width: product width + tree growth + one guard bit
//   pipe_lat    accept-to-out_valid latency in cycles for a given tap count
package conv_pkg;

   localparam int N_CH_D  = 3;
   localparam int K_D     = 5;
   localparam int DW_D    = 12;
   localparam int WW_D    = 8;
   localparam int BW_D    = 16;
   localparam int OUT_W_D = 14;
   localparam int SHIFT_D = 10;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int level_cnt(input int n, input int lvl);
      return (n + (1 << lvl) - 1) >> lvl;
   endfunction

   function automatic int acc_width(input int dw, input int ww, input int taps);
      return dw + ww + clog2(taps) + 1;
   endfunction

   // S0 input reg + tree input reg (holds the products) + tree levels + out reg.
   function automatic int pipe_lat(input int taps);
      return 3 + clog2(taps);
   endfunction

endpackage

// File: rtl/conv_add_tree.sv
// conv_add_tree: registered, pipelined binary adder tree with stall enable.
//   clk, rst   clock, synchronous active-high reset (clears the valid chain)
//   en         stage enable; every register, including valid bits, holds when low
//   in_valid   valid bit accompanying in_data
//   in_data    N terms of IN_W bits each, term i at [i*IN_W +: IN_W]
//   out_valid  valid bit of the completed sum
//   out_data   signed sum of all N terms
//   busy       any valid bit set inside the tree
// Level 0 registers the inputs; each of the clog2(N) following levels adds
// pairs and passes an unpaired odd term through registered.
module conv_add_tree
   import conv_pkg::*;
#(
   parameter int N    = 75,
   parameter int IN_W = 28
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              in_valid,
   input  logic [N*IN_W-1:0] in_data,
   output logic              out_valid,
   output logic [IN_W-1:0]   out_data,
   output logic              busy
);

   localparam int LV = clog2(N);

   // All levels share IN_W, which already includes the full growth of the
   // tree, so the sign extension at every level is implicit.
   logic signed [IN_W-1:0] node [0:LV][0:N-1];
   logic        [LV:0]     vld;

   // Keeps constant-bounded loop indices inside the array on dead branches.
   function automatic int idx(input int j);
      return (j < N) ? j : N - 1;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples the previous stage's value from before this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
      end else if (en) begin
         vld[0] <= in_valid;
         for (int l = 1; l <= LV; l++) vld[l] <= vld[l-1];
      end
   end

   // NOTE: the datapath is not reset; the valid chain alone decides whether
   // a register holds meaningful data, which keeps reset off the wide nets.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < N; i++) node[0][i] <= in_data[i*IN_W +: IN_W];
         for (int l = 1; l <= LV; l++) begin
            for (int i = 0; i < N; i++) begin
               if (2*i + 1 < level_cnt(N, l-1))
                  node[l][i] <= node[l-1][idx(2*i)] + node[l-1][idx(2*i+1)];
               else if (2*i < level_cnt(N, l-1))
                  node[l][i] <= node[l-1][idx(2*i)];
               else
                  node[l][i] <= '0;
            end
         end
      end
   end

   assign out_valid = vld[LV];
   assign out_data  = node[LV][0];
   assign busy      = |vld;

endmodule

// File: rtl/conv_mac_nch.sv
// conv_mac_nch: N-channel KxK convolution MAC, one output pixel per accepted window.
//   clk, rst    clock, synchronous active-high reset
//   in_valid    window valid; in_ready: window accepted when both high
//   in_data     flattened window, tap t = c*K*K + r*K + col at [t*DW +: DW]
//   w_we/w_addr/w_data   weight write (applied only when idle)
//   b_we/b_data          bias write (applied only when idle)
//   busy        any valid sample inside the pipeline
//   cfg_err     one-cycle pulse when a write is dropped or w_addr >= TAPS
//   out_valid/out_ready/out_data   result handshake, signed OUT_W result
// Pipeline: S0 input reg -> products (tree level 0) -> adder levels ->
// bias/round/shift/saturate/ReLU -> out reg. One global enable stalls all.
module conv_mac_nch
   import conv_pkg::*;
#(
   parameter int N_CH    = N_CH_D,
   parameter int K       = K_D,
   parameter int DW      = DW_D,
   parameter int WW      = WW_D,
   parameter int BW      = BW_D,
   parameter int OUT_W   = OUT_W_D,
   parameter int SHIFT   = SHIFT_D,
   parameter int ROUND   = 0,
   parameter int RELU_EN = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_CH*K*K*DW-1:0]        in_data,
   input  logic                          w_we,
   input  logic [clog2(N_CH*K*K)-1:0]    w_addr,
   input  logic [WW-1:0]                 w_data,
   input  logic                          b_we,
   input  logic [BW-1:0]                 b_data,
   output logic                          busy,
   output logic                          cfg_err,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OUT_W-1:0]              out_data
);

   localparam int TAPS  = N_CH * K * K;
   localparam int PW    = DW + WW;
   localparam int ACC_W = acc_width(DW, WW, TAPS);
   localparam int VW    = ACC_W + 2;  // room for bias add and rounding carry

   localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic signed [VW-1:0]    LIM_HI  = VW'(OUT_MAX);
   localparam logic signed [VW-1:0]    LIM_LO  = VW'(OUT_MIN);
   localparam logic signed [VW-1:0]    RND     =
      (ROUND != 0 && SHIFT > 0) ? (VW'(1) <<< (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;

   logic                      en;
   logic                      s0_valid;
   logic [TAPS*DW-1:0]        s0_data;
   logic signed [WW-1:0]      w_q [TAPS];
   logic signed [BW-1:0]      bias_q;
   logic [TAPS*ACC_W-1:0]     prod_flat;
   logic                      acc_valid;
   logic signed [ACC_W-1:0]   acc;
   logic                      tree_busy;
   logic                      cfg_ok;
   logic                      addr_ok;
   logic signed [VW-1:0]      so_sum;
   logic signed [VW-1:0]      so_shift;
   logic signed [OUT_W-1:0]   so_res;

   // Stall only when a result is waiting and downstream refuses it.
   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;
   assign busy     = s0_valid | tree_busy | out_valid;

   // ---------------- weight / bias register file ----------------
   assign cfg_ok  = !busy && !in_valid;
   assign addr_ok = 32'(w_addr) < TAPS;

   // Weights and bias must read as zero after reset, so they are reset
   // explicitly despite being a register file.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int t = 0; t < TAPS; t++) w_q[t] <= '0;
         bias_q <= '0;
      end else begin
         if (w_we && cfg_ok && addr_ok) w_q[w_addr] <= w_data;
         if (b_we && cfg_ok)            bias_q      <= b_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cfg_err <= 1'b0;
      else     cfg_err <= (w_we && !(cfg_ok && addr_ok)) || (b_we && !cfg_ok);
   end

   // ---------------- S0 input register ----------------
   always_ff @(posedge clk) begin
      if (rst)     s0_valid <= 1'b0;
      else if (en) s0_valid <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (en && in_valid) s0_data <= in_data;
   end

   // ---------------- S1 multiplies (registered as tree level 0) ----------------
   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      prod_flat = '0;
      for (int t = 0; t < TAPS; t++) begin
         prod_flat[t*ACC_W +: ACC_W] =
            ACC_W'(PW'(signed'(s0_data[t*DW +: DW])) * PW'(w_q[t]));
      end
   end

   conv_add_tree #(
      .N    (TAPS),
      .IN_W (ACC_W)
   ) u_tree (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (s0_valid),
      .in_data   (prod_flat),
      .out_valid (acc_valid),
      .out_data  (acc),
      .busy      (tree_busy)
   );

   // ---------------- SO: bias, round, shift, saturate, ReLU ----------------
   always_comb begin
      so_sum   = VW'(acc) + VW'(bias_q) + RND;
      so_shift = so_sum >>> SHIFT;
      if (so_shift > LIM_HI)      so_res = OUT_MAX;
      else if (so_shift < LIM_LO) so_res = OUT_MIN;
      else                        so_res = so_shift[OUT_W-1:0];
      if (RELU_EN != 0 && so_res[OUT_W-1]) so_res = '0;
   end

   // ---------------- output register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (en) begin
         out_valid <= acc_valid;
         if (acc_valid) out_data <= so_res;
      end
   end

endmodule

// File: tb/tb_conv_mac_nch.sv
// Directed bench for conv_mac_nch. Four instances share all inputs:
//   [0] defaults (SHIFT=10, floor)   [1] ROUND=1
//   [2] SHIFT=0                      [3] RELU_EN=1
// Inputs are driven and outputs sampled on the falling edge.
module tb_conv_mac_nch;

   localparam int TAPS = 75;
   localparam int DW   = 12;
   localparam int OW   = 14;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 out_ready = 1'b1;
   logic [TAPS*DW-1:0]   in_data = '0;
   logic                 w_we = 1'b0;
   logic [6:0]           w_addr = '0;
   logic [7:0]           w_data = '0;
   logic                 b_we = 1'b0;
   logic [15:0]          b_data = '0;

   logic                 rdy  [4];
   logic                 bsy  [4];
   logic                 cerr [4];
   logic                 ov   [4];
   logic [OW-1:0]        od   [4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   conv_mac_nch u_def (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .b_we(b_we), .b_data(b_data),
      .busy(bsy[0]), .cfg_err(cerr[0]), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(od[0]));

   conv_mac_nch #(.ROUND(1)) u_rnd (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .b_we(b_we), .b_data(b_data),
      .busy(bsy[1]), .cfg_err(cerr[1]), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(od[1]));

   conv_mac_nch #(.SHIFT(0)) u_s0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .b_we(b_we), .b_data(b_data),
      .busy(bsy[2]), .cfg_err(cerr[2]), .out_valid(ov[2]), .out_ready(out_ready),
      .out_data(od[2]));

   conv_mac_nch #(.RELU_EN(1)) u_relu (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_data(in_data),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .b_we(b_we), .b_data(b_data),
      .busy(bsy[3]), .cfg_err(cerr[3]), .out_valid(ov[3]), .out_ready(out_ready),
      .out_data(od[3]));

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sod(input int i);
      return int'($signed(od[i]));
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic fill(input int pix);
      for (int t = 0; t < TAPS; t++) in_data[t*DW +: DW] = DW'(pix);
   endtask

   task automatic set_tap(input int t, input int pix);
      in_data[t*DW +: DW] = DW'(pix);
   endtask

   task automatic wr_w(input int addr, input int val);
      w_we = 1'b1; w_addr = 7'(addr); w_data = 8'(val);
      tick();
      w_we = 1'b0;
   endtask

   task automatic all_w(input int val);
      for (int t = 0; t < TAPS; t++) wr_w(t, val);
   endtask

   // Waits (bounded) for out_valid on the default instance.
   task automatic wait_out(output int n);
      n = 0;
      while (!ov[0] && n < 40) begin
         tick();
         n++;
      end
   endtask

   // One window, presented in cycle 0; result expected in cycle 10.
   task automatic run_win(input string tag, input int e0, input int e1, input int e2, input int e3);
      int n;
      int e [4];
      e = '{e0, e1, e2, e3};
      check({tag, "_in_ready"}, int'(rdy[0]), 1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out(n);
      check({tag, "_latency"}, n + 1, 10);
      for (int i = 0; i < 4; i++) check($sformatf("%s_out%0d", tag, i), sod(i), e[i]);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int sent;
      int got;
      int held;
      int hold_flag;
      int stale;

      // ---------------- reset ----------------
      repeat (3) tick();
      check("rst_out_valid", int'(ov[0]), 0);
      check("rst_out_data", sod(0), 0);
      check("rst_busy", int'(bsy[0]), 0);
      check("rst_cfg_err", int'(cerr[0]), 0);
      rst = 1'b0;
      tick();
      check("rel_in_ready", int'(rdy[0]), 1);

      // ---------------- basic sums and saturation ----------------
      all_w(1); fill(1);
      run_win("ones", 0, 0, 75, 0);
      all_w(127); fill(2047);
      run_win("pos_sat", 8191, 8191, 8191, 8191);
      fill(-2048);
      run_win("neg_sat", -8192, -8192, -8192, 0);

      // ---------------- floor / round / ReLU on a single tap ----------------
      all_w(0); wr_w(0, 1); fill(0);
      set_tap(0, -1);
      run_win("acc_m1", -1, 0, -1, 0);
      set_tap(0, 1536);
      run_win("acc_1536", 1, 2, 1536, 1);
      wr_w(0, 5); set_tap(0, -1000);
      run_win("acc_m5000", -5, -5, -5000, 0);

      // ---------------- simultaneous weight + bias write ----------------
      w_we = 1'b1; w_addr = 7'd0; w_data = 8'd1; b_we = 1'b1; b_data = 16'd100;
      tick();
      w_we = 1'b0; b_we = 1'b0;
      check("dual_wr_err", int'(cerr[0]), 0);
      set_tap(0, -1);
      run_win("bias", 0, 0, 99, 0);
      b_we = 1'b1; b_data = 16'd0;
      tick();
      b_we = 1'b0;

      // ---------------- out-of-range address ----------------
      wr_w(75, 3);
      check("bad_addr_err", int'(cerr[0]), 1);
      tick();
      check("bad_addr_pulse", int'(cerr[0]), 0);

      // ---------------- write while busy is dropped ----------------
      all_w(1); fill(1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("busy_high", int'(bsy[0]), 1);
      wr_w(3, 7);
      check("busy_wr_err", int'(cerr[0]), 1);
      wait_out(n);
      check("busy_wr_valid", int'(ov[0]), 1);
      check("busy_wr_out", sod(2), 75);
      tick();
      run_win("after_drop", 0, 0, 75, 0);
      wr_w(3, 7);
      check("idle_wr_err", int'(cerr[0]), 0);
      run_win("tap3", 0, 0, 81, 0);

      // ---------------- streaming with a 5-cycle downstream stall ----------------
      sent = 0; got = 0; held = 0; hold_flag = 0;
      for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
         out_ready = !(cyc >= 12 && cyc < 17);
         in_valid  = (sent < 20);
         fill(sent + 1);
         #1;
         if (hold_flag != 0) check("stall_hold", sod(2), held);
         hold_flag = 0;
         if (ov[2] && !out_ready) begin
            check("stall_in_ready", int'(rdy[2]), 0);
            hold_flag = 1;
            held = sod(2);
         end
         if (ov[2] && out_ready) begin
            check($sformatf("stream_%0d", got), sod(2), 81 * (got + 1));
            got++;
         end
         if (in_valid && rdy[2]) sent++;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("stream_count", got, 20);
      tick();
      check("stream_idle", int'(bsy[0]), 0);

      // ---------------- reset with samples in flight ----------------
      fill(1);
      in_valid = 1'b1;
      repeat (4) tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      wait_out(n);
      check("rst_setup_valid", int'(ov[0]), 1);
      rst = 1'b1;
      tick();
      check("midrst_out_valid", int'(ov[0]), 0);
      check("midrst_busy", int'(bsy[0]), 0);
      rst = 1'b0;
      out_ready = 1'b1;
      stale = 0;
      repeat (20) begin
         tick();
         if (ov[0]) stale++;
      end
      check("no_stale_out", stale, 0);
      run_win("cleared", 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
